// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one CSR instruction (read old value, optional write) with legality checking.
module csr_access_unit (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [2:0]  i_funct3,
   input  logic [11:0] i_csr_addr,
   input  logic [31:0] i_rs1_val,
   input  logic [4:0]  i_rs1_idx,
   input  logic [31:0] i_csr_rdata,
   output logic [11:0] o_csr_select,
   output logic [31:0] o_csr_data,
   output logic        o_csr_load,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rd_data,
   output logic        o_illegal
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t state, state_nx;
   logic [2:0]  f3_q;
   logic [11:0] addr_q;
   logic [4:0]  idx_q;
   logic [31:0] rs1_q, old_q, rd_q, src, new_val;
   logic        legal_addr, wr_req, illegal;
   assign legal_addr = addr_q inside {12'hF14, 12'h300, 12'h341, 12'h100, 12'h144, 12'h104, 12'h304,
                                      12'h141, 12'h302, 12'h303, 12'h105, 12'h305, 12'h180, 12'h142,
                                      12'h143, 12'h306, 12'hC01, 12'h140, 12'h340};
   assign wr_req     = f3_q[1:0] == 2'b01 || idx_q != 5'd0;
   // addr[11:10]==11 marks the read-only CSR space
   assign illegal    = f3_q[1:0] == 2'b00 || !legal_addr || (addr_q[11:10] == 2'b11 && wr_req);
   assign src        = f3_q[2] ? {27'd0, idx_q} : rs1_q;
   assign new_val    = f3_q[1:0] == 2'b01 ? src : f3_q[1:0] == 2'b10 ? (old_q | src) : (old_q & ~src);
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         f3_q   <= '0;
         addr_q <= '0;
         idx_q  <= '0;
         rs1_q  <= '0;
         old_q  <= '0;
         rd_q   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && i_start) begin
            f3_q   <= i_funct3;
            addr_q <= i_csr_addr;
            idx_q  <= i_rs1_idx;
            rs1_q  <= i_rs1_val;
         end
         if (state == READ) begin
            old_q <= i_csr_rdata;
            rd_q  <= illegal ? 32'd0 : i_csr_rdata;
         end
      end
   end
   always_comb begin
      state_nx = state == IDLE  ? (i_start ? READ : IDLE) :
                 state == READ  ? ((!illegal && wr_req) ? WRITE : DONE) :
                 state == WRITE ? DONE : IDLE;
   end
   assign o_csr_select = (state == READ || state == WRITE) ? addr_q : 12'd0;
   assign o_csr_load   = state == WRITE;
   assign o_csr_data   = state == WRITE ? new_val : 32'd0;
   assign o_busy       = state != IDLE;
   assign o_done       = state == DONE;
   assign o_illegal    = state == DONE && illegal;
   assign o_rd_data    = rd_q;
endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 The unit SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The unit SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The unit SHALL have port i_start, input, 1 bit: request to execute one CSR instruction, sampled only in IDLE.
REQ-004 The unit SHALL have port i_funct3, input, 3 bits: CSR operation code (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
REQ-005 The unit SHALL have port i_csr_addr, input, 12 bits: target CSR address.
REQ-006 The unit SHALL have port i_rs1_val, input, 32 bits: rs1 register value.
REQ-007 The unit SHALL have port i_rs1_idx, input, 5 bits: rs1 index, which is also the zimm field for immediate forms.
REQ-008 The unit SHALL have port i_csr_rdata, input, 32 bits: current value of the CSR selected by o_csr_select, driven combinationally by the external read mux.
REQ-009 The unit SHALL have port o_csr_select, output, 12 bits: CSR address presented to the CSR file.
REQ-010 The unit SHALL have port o_csr_data, output, 32 bits: write data to the CSR file.
REQ-011 The unit SHALL have port o_csr_load, output, 1 bit: single-cycle CSR write strobe.
REQ-012 The unit SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The unit SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-014 The unit SHALL have port o_rd_data, output, 32 bits: old CSR value for rd; valid while o_done is high and held until the next start.
REQ-015 The unit SHALL have port o_illegal, output, 1 bit: qualifies o_done; the instruction was illegal.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-017 In IDLE with i_start=1, the unit SHALL latch funct3, addr, rs1_idx and rs1_val and go to READ; i_start SHALL be ignored in every other state.
REQ-018 o_csr_select SHALL equal the latched address in READ and WRITE.
REQ-019 In READ, the unit SHALL capture i_csr_rdata into the old-value register.
REQ-020 Source operand: rs1_val for funct3[2]=0, and the zero-extended 5-bit rs1_idx for funct3[2]=1.
REQ-021 New value: RW/RWI = src; RS/RSI = old | src; RC/RCI = old & ~src.
REQ-022 A write SHALL be required for RW/RWI always, and for set/clear forms only when rs1_idx != 0.
REQ-023 Legal address set: F14, 300, 341, 100, 144, 104, 304, 141, 302, 303, 105, 305, 180, 142, 143, 306, C01, 140, 340.
REQ-024 An instruction SHALL be illegal if funct3 is 000 or 100, the address is outside the legal set, or addr[11:10]=11 and a write is required.
REQ-025 From READ, the FSM SHALL go to WRITE if the instruction is legal and a write is required, otherwise to DONE.
REQ-026 In WRITE, the unit SHALL drive o_csr_load=1 and o_csr_data = new value for exactly one cycle, then go to DONE.
REQ-027 In DONE, the unit SHALL drive o_done=1, drive o_illegal per REQ-024, and drive o_rd_data = old value (0 if illegal), then go to IDLE.
REQ-028 Latency from the start-sample edge SHALL be: o_done high in the 3rd cycle with a write, or the 2nd cycle without a write.
REQ-029 o_csr_load SHALL never be asserted outside WRITE, and never for an illegal instruction.
REQ-030 Back-to-back operation: i_start held high SHALL begin a new instruction on the cycle after DONE (IDLE sample).

Reset
REQ-031 When i_rst=1, the unit SHALL go to IDLE and clear o_csr_load, o_done, o_illegal, o_busy, o_rd_data, o_csr_data and o_csr_select to 0.
REQ-032 Reset asserted in any state, including WRITE, SHALL take priority: no o_done is produced, and o_csr_load is 0 from the next cycle.

Verification
REQ-033 CSRRW 305, rs1_val=80000100, CSR rdata=0 -> load pulse with data 80000100 and select 305, done at cycle 3, rd=0.
REQ-034 CSRRS 300, rs1_val=8, old=2 -> write data 0000000A, rd=00000002; CSRRS with rs1_idx=0 -> no load, done at cycle 2, rd=old.
REQ-035 CSRRCI 304, zimm=5, old=FF -> write data FA, rd=FF; CSRRWI 140, zimm=1F -> write data 1F.
REQ-036 CSRRW F14 -> o_done with o_illegal=1, no load, rd=0; CSRRS F14, rs1_idx=0 -> legal, rd=mhartid value.
REQ-037 Address 7C0 or funct3=100 -> illegal, no load; i_start pulsed while busy -> ignored.
REQ-038 Assert i_rst during WRITE -> o_csr_load low on the next cycle, no o_done, IDLE, all outputs 0.
